// File: rtl/inst_prefetch_ctrl_pkg.sv
// Shared RV32I types, the next-line prefetch FSM encoding and line-address helpers.
// Pure declarations: no latency, no flow control.
package rv32i_types;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] rv32i_line;

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    DEMAND,
    RESPOND,
    PF_ISSUE,
    PREFETCH
  } pf_state_t;

  function automatic rv32i_word line_align(rv32i_word a, int unsigned off);
    return (a >> off) << off;
  endfunction

  // Wraps modulo 2^32: the top line's successor is line 0.
  function automatic rv32i_word next_line(rv32i_word a, int unsigned off);
    return ((a >> off) + 32'd1) << off;
  endfunction

endpackage

// File: rtl/inst_prefetch_ctrl_if.sv
// Line-fill channel: master holds address/read until the slave's one-cycle resp with rdata.
// No buffering; the requester holds read as its own backpressure.
interface inst_prefetch_ctrl_if;
  import rv32i_types::*;

  rv32i_word address;
  logic      read;
  logic      resp;
  rv32i_line rdata;

  modport master (output address, read, input resp, rdata);
  modport slave  (input address, read, output resp, rdata);
endinterface

// File: rtl/pf_line_buffer.sv
// One-entry prefetch line buffer; tag compare is combinational, all state registered.
// Clear has priority over a line write in the same cycle; rst drops valid synchronously.
module pf_line_buffer
  import rv32i_types::*;
#(
  parameter int TAG_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             tag_wr_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             line_wr_i,
  input  rv32i_line        line_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output rv32i_line        line_o
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  rv32i_line        line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      if (clr_i)          valid_q <= 1'b0;
      else if (line_wr_i) valid_q <= 1'b1;
      if (tag_wr_i)  tag_q  <= tag_i;
      if (line_wr_i) line_q <= line_i;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign line_o = line_q;

endmodule

// File: rtl/inst_prefetch_ctrl.sv
// Next-line instruction prefetcher (INST_PREFETCH_EN enables buffer/prefetch); hit 1 cycle, miss pf_resp+1.
// One arbiter transaction at a time; cache and arbiter both hold read until their resp.
module inst_prefetch_ctrl
  import rv32i_types::*;
#(
  parameter int s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  inst_prefetch_ctrl_if.slave  inst_pmem,
  inst_prefetch_ctrl_if.master pf
);

  localparam int TAG_W = 32 - s_offset;

  pf_state_t state_q;
  rv32i_word pf_addr_q;
  logic      pf_read_q;
  logic      resp_q;
  rv32i_line rdata_q;
  rv32i_word req_line;

  assign req_line        = line_align(inst_pmem.address, s_offset);
  assign inst_pmem.resp  = resp_q;
  assign inst_pmem.rdata = rdata_q;
  assign pf.read         = pf_read_q;
  assign pf.address      = pf_addr_q;

`ifdef INST_PREFETCH_EN
  rv32i_word req_addr_q;
  rv32i_word pf_next;
  logic      fused_q;
  logic      fused_d;
  logic      buf_hit;
  logic      buf_clr;
  logic      buf_line_wr;
  rv32i_line buf_line;

  assign pf_next = next_line(req_addr_q, s_offset);
  // A demand for the line already in flight rides on that burst instead of a new fetch.
  assign fused_d = fused_q ||
                   (inst_pmem.read && (inst_pmem.address[31:s_offset] == pf_addr_q[31:s_offset]));
  assign buf_clr     = (state_q == PF_ISSUE);
  assign buf_line_wr = (state_q == PREFETCH) && pf.resp && !fused_d;

  pf_line_buffer #(.TAG_W(TAG_W)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (buf_clr),
    .tag_wr_i     (buf_clr),
    .tag_i        (pf_next[31:s_offset]),
    .line_wr_i    (buf_line_wr),
    .line_i       (pf.rdata),
    .lookup_tag_i (inst_pmem.address[31:s_offset]),
    .hit_o        (buf_hit),
    .line_o       (buf_line)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pf_addr_q <= '0;
      pf_read_q <= 1'b0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
`ifdef INST_PREFETCH_EN
      req_addr_q <= '0;
      fused_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (inst_pmem.read) begin
`ifdef INST_PREFETCH_EN
            req_addr_q <= req_line;
            if (buf_hit) begin
              resp_q  <= 1'b1;
              rdata_q <= buf_line;
              state_q <= HIT;
            end else
`endif
            begin
              pf_read_q <= 1'b1;
              pf_addr_q <= req_line;
              state_q   <= DEMAND;
            end
          end
        end
        DEMAND: begin
          if (pf.resp) begin
            pf_read_q <= 1'b0;
            rdata_q   <= pf.rdata;
            resp_q    <= 1'b1;
            state_q   <= RESPOND;
          end
        end
        RESPOND: begin
          resp_q <= 1'b0;
`ifdef INST_PREFETCH_EN
          state_q <= PF_ISSUE;
`else
          state_q <= IDLE;
`endif
        end
`ifdef INST_PREFETCH_EN
        HIT: begin
          resp_q  <= 1'b0;
          state_q <= PF_ISSUE;
        end
        PF_ISSUE: begin
          pf_read_q <= 1'b1;
          pf_addr_q <= pf_next;
          fused_q   <= 1'b0;
          state_q   <= PREFETCH;
        end
        PREFETCH: begin
          fused_q <= fused_d;
          if (pf.resp) begin
            pf_read_q <= 1'b0;
            if (fused_d) begin
              rdata_q    <= pf.rdata;
              resp_q     <= 1'b1;
              req_addr_q <= pf_addr_q;
              state_q    <= RESPOND;
            end else begin
              state_q <= IDLE;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch_ctrl.sv
// Directed bench for inst_prefetch_ctrl with a 10-cycle arbiter model and response/address scoreboards.
// Covers the default build and, when INST_PREFETCH_EN is defined, the prefetch paths.
module tb_inst_prefetch_ctrl;
  import rv32i_types::*;

  localparam int LAT     = 10;
  localparam int K_MISS  = 0;
  localparam int K_HIT   = 1;
  localparam int K_FUSED = 2;
  localparam int K_OTHER = 3;

  typedef struct {
    rv32i_line data;
    bit        hit;
    int        req_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;
  int   last_pfr_cyc = 0;
  exp_t      exp_q[$];
  rv32i_word exp_pf[$];

  inst_prefetch_ctrl_if ifc_c ();
  inst_prefetch_ctrl_if ifc_p ();

  inst_prefetch_ctrl #(.s_offset(5)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .inst_pmem (ifc_c),
    .pf        (ifc_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rv32i_line mk_line(rv32i_word a);
    return {8{a}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not seen within its cycle budget", nm);
  endtask

  // Cache-side monitor first, then the arbiter model, both on the falling edge.
  initial begin : mon_and_mem
    int   cnt;
    exp_t e;
    cnt = 0;
    ifc_p.resp  = 1'b0;
    ifc_p.rdata = '0;
    forever begin
      @(negedge clk);
      if (ifc_c.resp) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_inst_resp");
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", ifc_c.rdata, e.data);
          chk("resp_cycle", cyc, e.hit ? e.req_cyc + 1 : last_pfr_cyc + 1);
        end
      end
      if (rst) begin
        cnt = 0;
        ifc_p.resp = 1'b0;
      end else if (ifc_p.resp) begin
        ifc_p.resp = 1'b0;
      end else if (ifc_p.read) begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          ifc_p.resp   = 1'b1;
          ifc_p.rdata  = mk_line(ifc_p.address);
          last_pfr_cyc = cyc;
          n_txn++;
          if (exp_pf.size() == 0) fail_now("unexpected_pf_txn");
          else chk("pf_txn_addr", ifc_p.address, exp_pf.pop_front());
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic req(input rv32i_word a, input int kind, input rv32i_word nxt);
    rv32i_word al;
    exp_t      e;
    int        k;
    al = line_align(a, 5);
    @(negedge clk);
    e.data    = mk_line(al);
    e.hit     = (kind == K_HIT);
    e.req_cyc = cyc;
    exp_q.push_back(e);
    if (kind == K_MISS || kind == K_OTHER) exp_pf.push_back(al);
`ifdef INST_PREFETCH_EN
    exp_pf.push_back(nxt);
`endif
    ifc_c.address = a;
    ifc_c.read    = 1'b1;
    @(negedge clk);
    if (kind == K_MISS) begin
      chk("demand_pf_read", ifc_p.read, 1'b1);
      chk("demand_pf_addr", ifc_p.address, al);
    end
    if (kind == K_HIT) chk("hit_no_demand", ifc_p.read, 1'b0);
    k = 0;
    while (!ifc_c.resp && k < 200) begin
      @(negedge clk);
      k++;
    end
    ifc_c.read = 1'b0;
    if (!ifc_c.resp) begin
      fail_now("inst_resp_timeout");
      return;
    end
    repeat (2) @(negedge clk);
`ifdef INST_PREFETCH_EN
    chk("prefetch_read", ifc_p.read, 1'b1);
    chk("prefetch_addr", ifc_p.address, nxt);
`else
    chk("no_spec_read", ifc_p.read, 1'b0);
`endif
  endtask

  task automatic wait_pf_idle();
    int k;
    k = 0;
    while (ifc_p.read && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (ifc_p.read) fail_now("pf_idle_timeout");
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inst_resp", ifc_c.resp, 1'b0);
    chk("rst_inst_rdata", ifc_c.rdata, '0);
    chk("rst_pf_read", ifc_p.read, 1'b0);
    chk("rst_pf_addr", ifc_p.address, '0);
`ifdef INST_PREFETCH_EN
    chk("rst_buf_valid", u_dut.u_buf.valid_q, 1'b0);
`endif
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    ifc_c.address = '0;
    ifc_c.read    = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

`ifdef INST_PREFETCH_EN
    req(32'h0000_0040, K_MISS, 32'h0000_0060);
    wait_pf_idle();
    chk("buf_valid_after_pf60", u_dut.u_buf.valid_q, 1'b1);
    req(32'h0000_0064, K_HIT, 32'h0000_0080);
    req(32'h0000_0080, K_FUSED, 32'h0000_00A0);
    wait_pf_idle();
    req(32'h0000_0060, K_MISS, 32'h0000_0080);
    begin
      int t0;
      t0 = n_txn;
      fork
        req(32'h0000_1000, K_OTHER, 32'h0000_1020);
        begin
          int k;
          k = 0;
          while (n_txn < t0 + 1 && k < 200) begin
            @(posedge clk);
            k++;
          end
          @(negedge clk);
          chk("buf_valid_after_pf80", u_dut.u_buf.valid_q, 1'b1);
        end
      join
    end
    wait_pf_idle();
    req(32'hFFFF_FFE0, K_MISS, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    chk("aborted_pf_pending", exp_pf.size(), 1);
    exp_pf.delete();
    rst = 1'b0;
    req(32'h0000_0000, K_MISS, 32'h0000_0020);
    wait_pf_idle();
`else
    req(32'h0000_0040, K_MISS, 32'h0);
    req(32'h0000_0064, K_MISS, 32'h0);
    req(32'hFFFF_FFE0, K_MISS, 32'h0);
    @(negedge clk);
    ifc_c.address = 32'h0000_0100;
    ifc_c.read    = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    ifc_c.read = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    req(32'h0000_0100, K_MISS, 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("pf_queue_drained", exp_pf.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
